// File: rtl/store_check.sv
// Store-stream checker: compares core stores against a loadable table of (address, data) pairs.
// Define STORE_CHECK_FAILCAP_EN to add fail_adr/fail_data capture of the offending store.
module store_check #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                N_CHECK  = 4,
  parameter logic [ADDR_W-1:0] IGN_ADR  = 32'd96,
  parameter logic [ADDR_W-1:0] IGN_MASK = 32'hFFFF_FFFC,
  parameter int                TIMEOUT  = 4096,
  localparam int               CW       = $clog2(N_CHECK + 1),
  localparam int               TW       = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_adr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic [CW-1:0]     start_count,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CW-1:0]     match_cnt
`ifdef STORE_CHECK_FAILCAP_EN
  ,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_data
`endif
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // ARMED | matching stores against the table, timer running
  // PASS  | all expected stores seen in order, verdict held
  // FAIL  | unexpected address, data mismatch or timeout, verdict held
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_ptr, w_ptr_nxt;
  logic [CW-1:0]       r_n, w_n_nxt;
  logic [TW-1:0]       r_timer, w_timer_nxt;
  logic                r_done, w_done_nxt;
  logic                r_pass, w_pass_nxt;
  logic [1:0]          r_fail_code, w_code_nxt;

  logic [ADDR_W-1:0]   r_exp_adr  [N_CHECK];
  logic [DATA_W-1:0]   r_exp_data [N_CHECK];
  logic [ADDR_W-1:0]   w_exp_adr;
  logic [DATA_W-1:0]   w_exp_data;

  logic                w_adr_hit, w_data_ok, w_ign, w_final, w_tmo;
  logic [CW-1:0]       w_n_clamp;

  // Out-of-range indices select nothing, which keeps the read mux lint-clean.
  always_comb begin
    w_exp_adr  = '0;
    w_exp_data = '0;
    for (int i = 0; i < N_CHECK; i++) begin
      if (r_ptr == CW'(i)) begin
        w_exp_adr  = r_exp_adr[i];
        w_exp_data = r_exp_data[i];
      end
    end
  end

  assign w_adr_hit = MemWrite && (DataAdr == w_exp_adr);
  assign w_data_ok = (WriteData == w_exp_data);
  assign w_ign     = MemWrite && ((DataAdr & IGN_MASK) == (IGN_ADR & IGN_MASK));
  assign w_final   = w_adr_hit && w_data_ok && ((r_ptr + CW'(1)) == r_n);
  assign w_tmo     = (r_timer == TW'(TIMEOUT - 1));
  assign w_n_clamp = (start_count > CW'(N_CHECK)) ? CW'(N_CHECK) : start_count;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_n_nxt     = r_n;
    w_timer_nxt = r_timer;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_code_nxt  = r_fail_code;
    if (start) begin
      w_state_nxt = S_ARMED;
      w_ptr_nxt   = '0;
      w_timer_nxt = '0;
      w_n_nxt     = w_n_clamp;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = 1'b0;
      w_code_nxt  = 2'd0;
    end else if (r_state == S_ARMED) begin
      w_timer_nxt = r_timer + TW'(1);
      // A final matching store wins over a timeout on the same edge.
      if (r_n == '0 || w_final) begin
        w_state_nxt = S_PASS;
        w_ptr_nxt   = w_final ? r_ptr + CW'(1) : r_ptr;
        w_done_nxt  = 1'b1;
        w_pass_nxt  = 1'b1;
      end else if (w_tmo) begin
        w_state_nxt = S_FAIL;
        w_done_nxt  = 1'b1;
        w_code_nxt  = 2'd3;
      end else if (w_adr_hit) begin
        if (w_data_ok) begin
          w_ptr_nxt = r_ptr + CW'(1);
        end else begin
          w_state_nxt = S_FAIL;
          w_done_nxt  = 1'b1;
          w_code_nxt  = 2'd2;
        end
      end else if (MemWrite && !w_ign) begin
        w_state_nxt = S_FAIL;
        w_done_nxt  = 1'b1;
        w_code_nxt  = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_n         <= '0;
      r_timer     <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_n         <= w_n_nxt;
      r_timer     <= w_timer_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_fail_code <= w_code_nxt;
    end
  end

  // Table is frozen while a check is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CHECK; i++) begin
        r_exp_adr[i]  <= '0;
        r_exp_data[i] <= '0;
      end
    end else if (cfg_we && r_state != S_ARMED) begin
      for (int i = 0; i < N_CHECK; i++) begin
        if (cfg_idx == CW'(i)) begin
          r_exp_adr[i]  <= cfg_adr;
          r_exp_data[i] <= cfg_data;
        end
      end
    end
  end

`ifdef STORE_CHECK_FAILCAP_EN
  logic [ADDR_W-1:0] r_fail_adr;
  logic [DATA_W-1:0] r_fail_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fail_adr  <= '0;
      r_fail_data <= '0;
    end else if (start) begin
      r_fail_adr  <= '0;
      r_fail_data <= '0;
    end else if (r_state == S_ARMED && w_state_nxt == S_FAIL) begin
      if (w_code_nxt == 2'd3) begin
        r_fail_adr  <= w_exp_adr;
        r_fail_data <= w_exp_data;
      end else begin
        r_fail_adr  <= DataAdr;
        r_fail_data <= WriteData;
      end
    end
  end

  assign fail_adr  = r_fail_adr;
  assign fail_data = r_fail_data;
`endif

  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_code = r_fail_code;
  assign match_cnt = r_ptr;

endmodule

// File: tb/tb_store_check.sv
// Scoreboard bench for store_check (TIMEOUT=16); fail capture checks compile in
// when STORE_CHECK_FAILCAP_EN is defined.
module tb_store_check;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_idx = '0;
  logic [AW-1:0] cfg_adr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic [CW-1:0] start_count = '0;
  logic          done, pass;
  logic [1:0]    fail_code;
  logic [CW-1:0] match_cnt;
`ifdef STORE_CHECK_FAILCAP_EN
  logic [AW-1:0] fail_adr;
  logic [DW-1:0] fail_data;
`endif

  always #5 clk = ~clk;

  store_check #(.N_CHECK(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_adr(cfg_adr), .cfg_data(cfg_data), .start(start),
    .start_count(start_count), .done(done), .pass(pass),
    .fail_code(fail_code), .match_cnt(match_cnt)
`ifdef STORE_CHECK_FAILCAP_EN
    , .fail_adr(fail_adr), .fail_data(fail_data)
`endif
  );

  typedef struct packed {
    logic          pass;
    logic [1:0]    code;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic [1:0] code, input logic [CW-1:0] cnt);
    exp_t e;
    e.pass = p;
    e.code = code;
    e.cnt  = cnt;
    sb_q.push_back(e);
  endtask

  task automatic cfg(input logic [CW-1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_adr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic arm(input logic [CW-1:0] n);
    start = 1'b1; start_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  // Waits a bounded number of cycles for done, then pops and compares the verdict.
  task automatic wait_verdict(input string tag, input int budget, output int cycles);
    exp_t e;
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_pass"}, pass, e.pass);
      chk({tag, "_code"}, fail_code, e.code);
      chk({tag, "_cnt"}, match_cnt, e.cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_cnt", match_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // scratch store ignored, then the expected store passes
    cfg(0, 100, 7);
    push_exp(1'b1, 2'd0, 1);
    arm(1);
    store(96, 32'hdead);
    chk("t1_ign_armed", done, 0);
    store(100, 7);
    wait_verdict("t1", 8, cyc);

    // data mismatch
    push_exp(1'b0, 2'd2, 0);
    arm(1);
    store(100, 8);
    wait_verdict("t2", 8, cyc);
`ifdef STORE_CHECK_FAILCAP_EN
    chk("t2_fail_adr", fail_adr, 100);
    chk("t2_fail_data", fail_data, 8);
`endif

    // ignore window edge, then unexpected address
    push_exp(1'b0, 2'd1, 0);
    arm(1);
    store(97, 0);
    chk("t3_ign_armed", done, 0);
    store(104, 7);
    wait_verdict("t3", 8, cyc);

    // timeout with no stores: done 16 cycles after arm
    push_exp(1'b0, 2'd3, 0);
    arm(1);
    wait_verdict("t4", 40, cyc);
    chk("t4_latency", cyc, 16);
`ifdef STORE_CHECK_FAILCAP_EN
    chk("t4_fail_adr", fail_adr, 100);
    chk("t4_fail_data", fail_data, 7);
`endif

    // matching final store on the timeout edge passes
    push_exp(1'b1, 2'd0, 1);
    arm(1);
    repeat (15) @(negedge clk);
    chk("t5_pre_done", done, 0);
    store(100, 7);
    wait_verdict("t5", 4, cyc);
    chk("t5_latency", cyc, 0);

    // reverse order
    cfg(1, 104, 9);
    push_exp(1'b0, 2'd1, 0);
    arm(2);
    store(104, 9);
    wait_verdict("t6", 8, cyc);

    // count clamped to table depth
    cfg(2, 108, 3);
    cfg(3, 112, 4);
    push_exp(1'b1, 2'd0, 4);
    arm(7);
    for (int i = 0; i < 4; i++) begin
      store(AW'(100 + 4 * i), DW'(i == 0 ? 7 : i == 1 ? 9 : i + 1));
      if (i < 3) chk("t7_progress", match_cnt, i + 1);
    end
    wait_verdict("t7", 8, cyc);

    // zero count passes on the first armed cycle
    push_exp(1'b1, 2'd0, 0);
    arm(0);
    wait_verdict("t8", 8, cyc);
    chk("t8_latency", cyc, 1);

    // table write while armed is ignored
    push_exp(1'b1, 2'd0, 1);
    arm(1);
    cfg(0, 200, 5);
    store(100, 7);
    wait_verdict("t9", 8, cyc);

    // start while armed restarts; the store in that cycle is not evaluated
    arm(2);
    store(100, 7);
    chk("t10_mid_cnt", match_cnt, 1);
    start = 1'b1; start_count = 2; MemWrite = 1'b1; DataAdr = 300; WriteData = 1;
    @(negedge clk);
    start = 1'b0; MemWrite = 1'b0;
    chk("t10_restart_cnt", match_cnt, 0);
    chk("t10_restart_done", done, 0);
    push_exp(1'b1, 2'd0, 2);
    store(100, 7);
    store(104, 9);
    wait_verdict("t10", 8, cyc);

    // async reset mid-armed clears outputs and table
    arm(2);
    store(100, 7);
    chk("t11_pre_cnt", match_cnt, 1);
    #2 reset = 1'b0;
    #1;
    chk("t11_rst_cnt", match_cnt, 0);
    chk("t11_rst_done", done, 0);
    chk("t11_rst_code", fail_code, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_exp(1'b0, 2'd1, 0);
    arm(1);
    store(100, 7);
    wait_verdict("t11", 8, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
